// File: rtl/exc_pkg.sv
// Shared constants for the commit-stage exception arbiter: flag order, ExcCodes,
// vector offsets, cause encoding and FSM states.
package exc_pkg;

    // Flag bit positions inside exc_flags
    localparam int EXC_IF_ADEL = 0;
    localparam int EXC_IF_TLBR = 1;
    localparam int EXC_IF_TLBI = 2;
    localparam int EXC_RI      = 3;
    localparam int EXC_SYS     = 4;
    localparam int EXC_BP      = 5;
    localparam int EXC_OV      = 6;
    localparam int EXC_D_ADE   = 7;
    localparam int EXC_D_TLBR  = 8;
    localparam int EXC_D_TLBI  = 9;
    localparam int EXC_MOD     = 10;
    localparam int EXC_ERET    = 11;
    localparam int EXC_NUM     = 12;

    // Cause vector = {gated flags, interrupt}; index 0 is highest priority
    localparam int CAUSE_NUM = EXC_NUM + 1;
    localparam int CAUSE_W   = $clog2(CAUSE_NUM);

    localparam logic [CAUSE_W-1:0] C_INT     = CAUSE_W'(0);
    localparam logic [CAUSE_W-1:0] C_IF_ADEL = CAUSE_W'(EXC_IF_ADEL + 1);
    localparam logic [CAUSE_W-1:0] C_IF_TLBR = CAUSE_W'(EXC_IF_TLBR + 1);
    localparam logic [CAUSE_W-1:0] C_IF_TLBI = CAUSE_W'(EXC_IF_TLBI + 1);
    localparam logic [CAUSE_W-1:0] C_RI      = CAUSE_W'(EXC_RI + 1);
    localparam logic [CAUSE_W-1:0] C_SYS     = CAUSE_W'(EXC_SYS + 1);
    localparam logic [CAUSE_W-1:0] C_BP      = CAUSE_W'(EXC_BP + 1);
    localparam logic [CAUSE_W-1:0] C_OV      = CAUSE_W'(EXC_OV + 1);
    localparam logic [CAUSE_W-1:0] C_D_ADE   = CAUSE_W'(EXC_D_ADE + 1);
    localparam logic [CAUSE_W-1:0] C_D_TLBR  = CAUSE_W'(EXC_D_TLBR + 1);
    localparam logic [CAUSE_W-1:0] C_D_TLBI  = CAUSE_W'(EXC_D_TLBI + 1);
    localparam logic [CAUSE_W-1:0] C_MOD     = CAUSE_W'(EXC_MOD + 1);
    localparam logic [CAUSE_W-1:0] C_ERET    = CAUSE_W'(EXC_ERET + 1);

    localparam logic [4:0] EX_INT  = 5'd0;
    localparam logic [4:0] EX_MOD  = 5'd1;
    localparam logic [4:0] EX_TLBL = 5'd2;
    localparam logic [4:0] EX_TLBS = 5'd3;
    localparam logic [4:0] EX_ADEL = 5'd4;
    localparam logic [4:0] EX_ADES = 5'd5;
    localparam logic [4:0] EX_SYS  = 5'd8;
    localparam logic [4:0] EX_BP   = 5'd9;
    localparam logic [4:0] EX_RI   = 5'd10;
    localparam logic [4:0] EX_OV   = 5'd12;

    localparam logic [31:0] OFF_REFILL  = 32'h0000_0000;
    localparam logic [31:0] OFF_GENERAL = 32'h0000_0180;
    localparam logic [31:0] OFF_INT     = 32'h0000_0200;

    typedef enum logic [1:0] {
        BVA_NONE = 2'd0,
        BVA_INST = 2'd1,
        BVA_DATA = 2'd2
    } bva_sel_e;

    typedef enum logic {
        S_IDLE     = 1'b0,
        S_REDIRECT = 1'b1
    } state_e;

    // Data-side address/TLB faults report the store flavour when data_we is set
    function automatic logic [4:0] cause_code(input logic [CAUSE_W-1:0] c, input logic we);
        logic [4:0] code;
        code = EX_INT;
        case (c)
            C_INT:     code = EX_INT;
            C_IF_ADEL: code = EX_ADEL;
            C_IF_TLBR: code = EX_TLBL;
            C_IF_TLBI: code = EX_TLBL;
            C_RI:      code = EX_RI;
            C_SYS:     code = EX_SYS;
            C_BP:      code = EX_BP;
            C_OV:      code = EX_OV;
            C_D_ADE:   code = we ? EX_ADES : EX_ADEL;
            C_D_TLBR:  code = we ? EX_TLBS : EX_TLBL;
            C_D_TLBI:  code = we ? EX_TLBS : EX_TLBL;
            C_MOD:     code = EX_MOD;
            default:   code = EX_INT;
        endcase
        return code;
    endfunction

    function automatic bva_sel_e cause_bva(input logic [CAUSE_W-1:0] c);
        bva_sel_e sel;
        sel = BVA_NONE;
        case (c)
            C_IF_ADEL, C_IF_TLBR, C_IF_TLBI:         sel = BVA_INST;
            C_D_ADE, C_D_TLBR, C_D_TLBI, C_MOD:      sel = BVA_DATA;
            default:                                 sel = BVA_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// Combinational priority encoder: lowest set bit wins by default, highest set
// bit wins with MSB_FIRST. Also maps the winner to ExcCode / BadVAddr source.
module exc_prio_enc
    import exc_pkg::*;
#(
    parameter int W         = CAUSE_NUM,
    parameter bit MSB_FIRST = 1'b0,
    parameter int IW        = $clog2(W)
) (
    input  logic [W-1:0]  i_req,
    input  logic          i_data_we,
    output logic          o_hit,
    output logic [IW-1:0] o_idx,
    output logic [4:0]    o_code,
    output bva_sel_e      o_bva_sel
);

    always_comb begin
        o_hit = |i_req;
        o_idx = '0;
        if (MSB_FIRST) begin
            for (int i = 0; i < W; i++)
                if (i_req[i]) o_idx = IW'(i);
        end else begin
            for (int i = W - 1; i >= 0; i--)
                if (i_req[i]) o_idx = IW'(i);
        end
    end

    assign o_code    = cause_code(CAUSE_W'(o_idx), i_data_we);
    assign o_bva_sel = cause_bva(CAUSE_W'(o_idx));

endmodule

// File: rtl/exc_arbiter.sv
// Precise-exception arbiter at commit: picks the winning cause, registers the CP0
// update and holds a flush/redirect until fetch accepts it.
// Optional macro EXC_VECTORED_INT_EN selects per-IRQ interrupt vectors.
module exc_arbiter
    import exc_pkg::*;
#(
    parameter int          NUM_FLUSH   = 4,
    parameter int          NUM_IRQ     = 8,
    parameter logic [31:0] EBASE       = 32'hBFC0_0200,
    parameter logic [31:0] VEC_SPACING = 32'h20
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_int_allow,
    input  logic                 i_exl,
    input  logic [NUM_IRQ-1:0]   i_irq_pending,
    input  logic                 i_commit_valid,
    input  logic [EXC_NUM-1:0]   i_exc_flags,
    input  logic [31:0]          i_commit_pc,
    input  logic                 i_commit_in_ds,
    input  logic [31:0]          i_inst_vaddr,
    input  logic [31:0]          i_data_vaddr,
    input  logic                 i_data_we,
    input  logic [31:0]          i_epc_in,
    input  logic                 i_redirect_ready,
    output logic                 o_exc_pending,
    output logic [NUM_FLUSH-1:0] o_flush,
    output logic                 o_redirect_valid,
    output logic [31:0]          o_redirect_pc,
    output logic                 o_cp0_we_exc,
    output logic [4:0]           o_exc_code,
    output logic [31:0]          o_epc_out,
    output logic                 o_bd_out,
    output logic [31:0]          o_badvaddr,
    output logic                 o_badvaddr_we,
    output logic                 o_clear_exl
);

    state_e               r_state, w_state_nxt;
    logic [CAUSE_NUM-1:0] w_cause;
    logic                 w_hit, w_take, w_is_eret, w_is_int, w_refill;
    logic [CAUSE_W-1:0]   w_cidx;
    logic [4:0]           w_code;
    bva_sel_e             w_bva_sel;
    logic [31:0]          w_int_vec, w_vec;

    logic [31:0] r_redirect_pc, r_epc, r_badvaddr;
    logic [4:0]  r_exc_code;
    logic        r_bd, r_cp0_we, r_bva_we, r_clear_exl;

    // Interrupts bypass commit_valid; everything else needs a live instruction
    assign w_cause = {i_exc_flags & {EXC_NUM{i_commit_valid}},
                      i_int_allow & (|i_irq_pending)};

    exc_prio_enc #(.W(CAUSE_NUM), .MSB_FIRST(1'b0), .IW(CAUSE_W)) u_cause_enc (
        .i_req     (w_cause),
        .i_data_we (i_data_we),
        .o_hit     (w_hit),
        .o_idx     (w_cidx),
        .o_code    (w_code),
        .o_bva_sel (w_bva_sel)
    );

`ifdef EXC_VECTORED_INT_EN
    localparam int IRQ_IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
    localparam int VEC_SH = $clog2(VEC_SPACING);

    logic              w_irq_hit;
    logic [IRQ_IW-1:0] w_irq_idx;
    logic [4:0]        w_irq_code;
    bva_sel_e          w_irq_bva;

    exc_prio_enc #(.W(NUM_IRQ), .MSB_FIRST(1'b1), .IW(IRQ_IW)) u_irq_enc (
        .i_req     (i_irq_pending),
        .i_data_we (1'b0),
        .o_hit     (w_irq_hit),
        .o_idx     (w_irq_idx),
        .o_code    (w_irq_code),
        .o_bva_sel (w_irq_bva)
    );

    // VEC_SPACING is a power of two, so the index multiply is a shift
    assign w_int_vec = EBASE + OFF_INT + (32'(w_irq_idx) << VEC_SH);
`else
    assign w_int_vec = EBASE + OFF_GENERAL;
`endif

    assign w_take    = (r_state == S_IDLE) && w_hit;
    assign w_is_eret = (w_cidx == C_ERET);
    assign w_is_int  = (w_cidx == C_INT);
    assign w_refill  = ((w_cidx == C_IF_TLBR) || (w_cidx == C_D_TLBR)) && !i_exl;

    always_comb begin
        w_vec = EBASE + OFF_GENERAL;
        if (w_is_eret)     w_vec = i_epc_in;
        else if (w_is_int) w_vec = w_int_vec;
        else if (w_refill) w_vec = EBASE + OFF_REFILL;
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Triggers arriving while redirecting are dropped; the pipeline replays them
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     if (w_hit) w_state_nxt = S_REDIRECT;
            S_REDIRECT: if (i_redirect_ready) w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_redirect_pc <= '0;
            r_epc         <= '0;
            r_badvaddr    <= '0;
            r_exc_code    <= '0;
            r_bd          <= 1'b0;
            r_cp0_we      <= 1'b0;
            r_bva_we      <= 1'b0;
            r_clear_exl   <= 1'b0;
        end else begin
            r_cp0_we    <= 1'b0;
            r_bva_we    <= 1'b0;
            r_clear_exl <= 1'b0;
            if (w_take) begin
                r_redirect_pc <= w_vec;
                if (w_is_eret) begin
                    r_clear_exl <= 1'b1;
                end else begin
                    r_cp0_we   <= 1'b1;
                    r_exc_code <= w_code;
                    r_epc      <= i_commit_in_ds ? i_commit_pc - 32'd4 : i_commit_pc;
                    r_bd       <= i_commit_in_ds;
                    case (w_bva_sel)
                        BVA_INST: begin
                            r_badvaddr <= i_inst_vaddr;
                            r_bva_we   <= 1'b1;
                        end
                        BVA_DATA: begin
                            r_badvaddr <= i_data_vaddr;
                            r_bva_we   <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign o_exc_pending    = w_take && !reset;
    assign o_flush          = {NUM_FLUSH{r_state == S_REDIRECT}};
    assign o_redirect_valid = (r_state == S_REDIRECT);
    assign o_redirect_pc    = r_redirect_pc;
    assign o_cp0_we_exc     = r_cp0_we;
    assign o_exc_code       = r_exc_code;
    assign o_epc_out        = r_epc;
    assign o_bd_out         = r_bd;
    assign o_badvaddr       = r_badvaddr;
    assign o_badvaddr_we    = r_bva_we;
    assign o_clear_exl      = r_clear_exl;

endmodule
